dispatch_credit_ctrl: RTL
=========================

// Module: dispatch_credit_ctrl
// PURPOSE
//  N-way dispatch hazard controller between the instruction buffer and ID/dispatch.
//  Keeps registered credit counters for ROB slots, RS entries and free-list regs.
//  Each cycle grants haz_nDispatched = min(WIDTH, ib count, every credit).
//  On a branch mispredict it squashes dispatch, waits for rollback, then resyncs credits.
// PARAMETERS
//  WIDTH          2   max insns dispatched/retired/issued/freed per cycle
//  ROB_DEPTH     32   ROB entries; ROB credit reset value
//  RS_DEPTH       8   RS entries; RS credit reset value
//  FL_DEPTH      32   free physical regs at reset; FL credit reset value
//  RETIRE_BYPASS  1   1: this cycle's rob_nRetired adds to ROB availability the same cycle
// PORTS  (NW = $clog2(WIDTH+1); CW = $clog2(max depth+1))
//  clock              in   1    system clock
//  reset              in   1    synchronous, active-high
//  ib_nIsnBuffer      in   NW   valid insns at buffer head, 0..WIDTH
//  rob_nRetired       in   NW   ROB entries retired this cycle
//  rs_nIssued         in   NW   RS entries freed by issue this cycle
//  fl_nFreed          in   NW   phys regs returned to free list this cycle
//  br_pred_wrong      in   1    mispredict pulse
//  rollback_done      in   1    ROB/RS/FL recovery complete; sync counts valid
//  rob_free_sync      in   CW   authoritative free ROB slots (read in RESYNC only)
//  rs_free_sync       in   CW   authoritative free RS entries (read in RESYNC only)
//  fl_free_sync       in   CW   authoritative free regs (read in RESYNC only)
//  haz_nDispatched    out  NW   insns dispatched this cycle
//  haz_busy           out  1    FSM not in RUN
//  haz_credit_err     out  1    sticky: credit over/underflow detected
// BEHAVIOUR
//  - Reset: credits = ROB_DEPTH/RS_DEPTH/FL_DEPTH; FSM = RUN; haz_busy = 0; err = 0.
//    haz_nDispatched evaluates to min(WIDTH, ib_nIsnBuffer) after reset.
//  - Grant is combinational from registered state plus inputs, with zero latency.
//    rob_av = rob_cr + (RETIRE_BYPASS ? rob_nRetired : 0). RS and FL have no bypass.
//    grant = min(WIDTH, ib_nIsnBuffer, rob_av, rs_cr, fl_cr) in RUN; 0 otherwise.
//  - Comparisons are done at CW+1 bits, so the bypass add cannot wrap.
//  - Credit update each RUN cycle: cr_next = cr - grant + released.
//    released = rob_nRetired / rs_nIssued / fl_nFreed respectively.
//    Retire and issue this cycle combine with dispatch in a single update.
//  - Each dispatched insn consumes one ROB, one RS and one FL credit.
//  - If cr_next > DEPTH or cr_next < 0: clamp to DEPTH / 0 and set haz_credit_err.
//    haz_credit_err clears only on reset.
//  - FSM:
//    RUN    -> SQUASH when br_pred_wrong. Grant is forced to 0 that same cycle.
//              Credits are not updated in that cycle.
//    SQUASH -> RESYNC unconditionally (1 cycle). grant = 0. Release inputs ignored.
//    RESYNC -> stays while !rollback_done, grant = 0.
//              On rollback_done, credits load from *_free_sync; then -> RUN.
//              The first dispatch happens the next cycle.
//    br_pred_wrong in SQUASH/RESYNC -> return to SQUASH (the recovery restarts).
//  - haz_busy = (state != RUN), registered.
//  - ib_nIsnBuffer > WIDTH is treated as WIDTH.
//  - Reset in any state wins over every other input.
// STRUCTURE
//  - Shared package (dispatch_pkg): typedef enum {RUN, SQUASH, RESYNC} disp_state_t.
//    Also holds the NW/CW width localparam functions and default depth constants.
//  - One sub-module, credit_counter: DEPTH param; sub/add/load/clamp/err.
//    Instantiated 3x (ROB, RS, FL). Top holds min-tree, bypass and FSM.
// TESTING (WIDTH=2, ROB=32, RS=8, FL=32 unless noted)
//  1. After reset, ib=2, no releases, held 5 cycles.
//     -> grant=2,2,2,2,0; rs_cr goes 8,6,4,2,0,0.
//  2. RS empty (rs_cr=0), rs_nIssued=1 same cycle.
//     -> grant=0 that cycle, grant=1 next cycle (no RS bypass).
//  3. rob_cr=0, rob_nRetired=2, ib=2, RETIRE_BYPASS=1 -> grant=2, rob_cr stays 0.
//     Same with RETIRE_BYPASS=0 -> grant=0, rob_cr becomes 2.
//  4. br_pred_wrong with ib=2 in RUN -> grant=0 that cycle; SQUASH 1 cycle.
//     RESYNC holds grant=0 for 3 cycles; rollback_done with sync=20/5/25.
//     -> credits=20/5/25; grant=2 the cycle after.
//  5. Second br_pred_wrong while in RESYNC -> returns to SQUASH.
//     rollback_done in that SQUASH cycle is ignored; haz_busy stays 1.
//  6. fl_cr=32 and fl_nFreed=1 -> fl_cr stays 32 and haz_credit_err=1.
//     err persists until reset; reset asserted mid-RESYNC -> RUN with full credits.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch credit controller.
//   disp_state_t : recovery FSM states (RUN, SQUASH, RESYNC)
//   nw_f         : width of a per-cycle instruction count, 0..width
//   cw_f         : width of a credit counter able to hold the largest depth
//   DEF_*        : default width/depth parameters
package dispatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        RESYNC = 2'd2
    } disp_state_t;

    localparam int DEF_WIDTH     = 2;
    localparam int DEF_ROB_DEPTH = 32;
    localparam int DEF_RS_DEPTH  = 8;
    localparam int DEF_FL_DEPTH  = 32;

    function automatic int nw_f(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int cw_f(input int d0, input int d1, input int d2);
        int m;
        m = d0;
        if (d1 > m) m = d1;
        if (d2 > m) m = d2;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dispatch_credit_ctrl_credit_counter.sv
// Saturating credit counter for one resource (ROB, RS or free list).
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   upd          : apply cr - sub + add this cycle
//   sub          : credits consumed by dispatch
//   add          : credits returned by the backend
//   load         : overwrite the count with load_val (resync after recovery)
//   load_val     : authoritative free count
//   cr           : current credit count (resets to DEPTH)
//   err          : sticky, set when an update or load leaves 0..DEPTH
module credit_counter
#(
    parameter int DEPTH = 8,
    parameter int NW    = 2,
    parameter int CW    = 4
)(
    input  logic          clock,
    input  logic          reset,
    input  logic          upd,
    input  logic [NW-1:0] sub,
    input  logic [NW-1:0] add,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cr,
    output logic          err
);

    localparam logic [CW-1:0]        DEPTH_U = CW'(DEPTH);
    localparam logic signed [CW+1:0] DEPTH_S = (CW+2)'(DEPTH);

    // Two guard bits: one for the add overshoot, one for the sign.
    logic signed [CW+1:0] nxt;
    assign nxt = $signed({2'b00, cr}) + $signed((CW+2)'(add)) - $signed((CW+2)'(sub));

    always_ff @(posedge clock) begin
        if (reset) begin
            cr  <= DEPTH_U;
            err <= 1'b0;
        end else if (load) begin
            if (load_val > DEPTH_U) begin
                cr  <= DEPTH_U;
                err <= 1'b1;
            end else begin
                cr  <= load_val;
            end
        end else if (upd) begin
            if (nxt[CW+1]) begin
                cr  <= '0;
                err <= 1'b1;
            end else if (nxt > DEPTH_S) begin
                cr  <= DEPTH_U;
                err <= 1'b1;
            end else begin
                cr  <= nxt[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// N-way dispatch hazard controller between the instruction buffer and dispatch.
// Grants min(WIDTH, buffer count, ROB/RS/FL credits) each RUN cycle and runs a
// squash/resync sequence on a branch mispredict.
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   ib_nIsnBuffer      : valid instructions at buffer head (values > WIDTH act as WIDTH)
//   rob_nRetired       : ROB entries retired this cycle
//   rs_nIssued         : RS entries freed this cycle
//   fl_nFreed          : physical regs returned this cycle
//   br_pred_wrong      : mispredict pulse, starts or restarts recovery
//   rollback_done      : recovery complete, *_free_sync valid
//   rob/rs/fl_free_sync: authoritative free counts loaded at end of RESYNC
//   haz_nDispatched    : instructions dispatched this cycle
//   haz_busy           : registered, high while not in RUN
//   haz_credit_err     : sticky credit over/underflow flag
//
// state  | meaning
// RUN    | normal dispatch, credits track grant and releases
// SQUASH | one cycle after a mispredict, no dispatch, releases ignored
// RESYNC | waiting for rollback_done, then load credits from sync inputs
module dispatch_credit_ctrl
    import dispatch_pkg::*;
#(
    parameter int  WIDTH         = DEF_WIDTH,
    parameter int  ROB_DEPTH     = DEF_ROB_DEPTH,
    parameter int  RS_DEPTH      = DEF_RS_DEPTH,
    parameter int  FL_DEPTH      = DEF_FL_DEPTH,
    parameter bit  RETIRE_BYPASS = 1'b1,
    localparam int NW            = nw_f(WIDTH),
    localparam int CW            = cw_f(ROB_DEPTH, RS_DEPTH, FL_DEPTH)
)(
    input  logic          clock,
    input  logic          reset,
    input  logic [NW-1:0] ib_nIsnBuffer,
    input  logic [NW-1:0] rob_nRetired,
    input  logic [NW-1:0] rs_nIssued,
    input  logic [NW-1:0] fl_nFreed,
    input  logic          br_pred_wrong,
    input  logic          rollback_done,
    input  logic [CW-1:0] rob_free_sync,
    input  logic [CW-1:0] rs_free_sync,
    input  logic [CW-1:0] fl_free_sync,
    output logic [NW-1:0] haz_nDispatched,
    output logic          haz_busy,
    output logic          haz_credit_err
);

    localparam int MW = CW + 1;

    disp_state_t   state;
    logic [CW-1:0] rob_cr, rs_cr, fl_cr;
    logic          rob_err, rs_err, fl_err;

    logic [NW-1:0] ib_eff;
    logic [MW-1:0] ib_ext, rob_av, rs_av, fl_av, lim_a, lim_b, lim;
    logic          dispatch_ok, load_sync;

    assign ib_eff = (int'(ib_nIsnBuffer) > WIDTH) ? NW'(WIDTH) : ib_nIsnBuffer;
    assign ib_ext = MW'(ib_eff);

    // Compared at CW+1 bits so the retire bypass cannot wrap.
    assign rob_av = MW'(rob_cr) + (RETIRE_BYPASS ? MW'(rob_nRetired) : MW'(0));
    assign rs_av  = MW'(rs_cr);
    assign fl_av  = MW'(fl_cr);

    assign lim_a = (ib_ext < rob_av) ? ib_ext : rob_av;
    assign lim_b = (rs_av < fl_av) ? rs_av : fl_av;
    assign lim   = (lim_a < lim_b) ? lim_a : lim_b;

    // A mispredict kills dispatch and the credit update in the same cycle.
    assign dispatch_ok     = (state == RUN) && !br_pred_wrong;
    assign load_sync       = (state == RESYNC) && rollback_done && !br_pred_wrong;
    assign haz_nDispatched = dispatch_ok ? lim[NW-1:0] : '0;
    assign haz_credit_err  = rob_err | rs_err | fl_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            haz_busy <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (br_pred_wrong) begin
                        state    <= SQUASH;
                        haz_busy <= 1'b1;
                    end
                end
                SQUASH: begin
                    state    <= br_pred_wrong ? SQUASH : RESYNC;
                    haz_busy <= 1'b1;
                end
                RESYNC: begin
                    if (br_pred_wrong) begin
                        state    <= SQUASH;
                        haz_busy <= 1'b1;
                    end else if (rollback_done) begin
                        state    <= RUN;
                        haz_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    haz_busy <= 1'b0;
                end
            endcase
        end
    end

    credit_counter #(.DEPTH(ROB_DEPTH), .NW(NW), .CW(CW)) u_rob (
        .clock    (clock),
        .reset    (reset),
        .upd      (dispatch_ok),
        .sub      (haz_nDispatched),
        .add      (rob_nRetired),
        .load     (load_sync),
        .load_val (rob_free_sync),
        .cr       (rob_cr),
        .err      (rob_err)
    );

    credit_counter #(.DEPTH(RS_DEPTH), .NW(NW), .CW(CW)) u_rs (
        .clock    (clock),
        .reset    (reset),
        .upd      (dispatch_ok),
        .sub      (haz_nDispatched),
        .add      (rs_nIssued),
        .load     (load_sync),
        .load_val (rs_free_sync),
        .cr       (rs_cr),
        .err      (rs_err)
    );

    credit_counter #(.DEPTH(FL_DEPTH), .NW(NW), .CW(CW)) u_fl (
        .clock    (clock),
        .reset    (reset),
        .upd      (dispatch_ok),
        .sub      (haz_nDispatched),
        .add      (fl_nFreed),
        .load     (load_sync),
        .load_val (fl_free_sync),
        .cr       (fl_cr),
        .err      (fl_err)
    );

endmodule
